// File: rtl/coll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coll_pkg
// Description : Shared definitions for the collision scan controller:
//               contact side bit positions, sprite dimensions, geometry
//               width and the scan state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package coll_pkg;

  // Bit positions inside collision_state = {right, left, up, down}
  localparam int SIDE_DOWN  = 0;
  localparam int SIDE_UP    = 1;
  localparam int SIDE_LEFT  = 2;
  localparam int SIDE_RIGHT = 3;

  // Sprite sizes in pixels
  localparam int PLAYER_W = 47;
  localparam int PLAYER_H = 41;
  localparam int BLOCK_W  = 28;
  localparam int BLOCK_H  = 42;

  // Geometry width: 10-bit x plus the largest offset (47) never exceeds 11 bits
  localparam int GEO_W = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/collision_cmp.sv
`default_nettype none
// ============================================================================
// Module      : collision_cmp
// Description : Combinational single-block edge-contact comparator. Compares
//               the player box against one ground block and reports which
//               sides are touching (edges adjacent, not overlapping).
// Ports       : px, py   - player left x / top y
//               bx, by   - block left x / top y
//               side     - {right, left, up, down} contacts for this block
//               touch    - player is standing on this block (same as down)
// Revision    : 1.0 - initial release
// ============================================================================
module collision_cmp
  import coll_pkg::*;
(
  input  logic [9:0] px,
  input  logic [8:0] py,
  input  logic [9:0] bx,
  input  logic [8:0] by,
  output logic [3:0] side,
  output logic       touch
);

  localparam logic [GEO_W-1:0] C_PW   = GEO_W'(PLAYER_W);
  localparam logic [GEO_W-1:0] C_PW_1 = GEO_W'(PLAYER_W - 1);
  localparam logic [GEO_W-1:0] C_PH_1 = GEO_W'(PLAYER_H - 1);
  localparam logic [GEO_W-1:0] C_PH   = GEO_W'(PLAYER_H);
  localparam logic [GEO_W-1:0] C_BW   = GEO_W'(BLOCK_W);
  localparam logic [GEO_W-1:0] C_BW_1 = GEO_W'(BLOCK_W - 1);
  localparam logic [GEO_W-1:0] C_BH   = GEO_W'(BLOCK_H);
  localparam logic [GEO_W-1:0] C_BH_1 = GEO_W'(BLOCK_H - 1);

  // Zero-extend so edge sums near the screen border cannot wrap
  logic [GEO_W-1:0] pxw, pyw, bxw, byw;
  logic             x_ov, y_ov;

  always_comb begin
    pxw  = {1'b0, px};
    pyw  = {2'b00, py};
    bxw  = {1'b0, bx};
    byw  = {2'b00, by};
    x_ov = (pxw + C_PW_1 >= bxw) && (pxw <= bxw + C_BW_1);
    y_ov = (pyw + C_PH_1 >= byw) && (pyw <= byw + C_BH_1);

    side             = 4'b0000;
    side[SIDE_DOWN]  = x_ov && (pyw + C_PH == byw);
    side[SIDE_UP]    = x_ov && (pyw == byw + C_BH);
    side[SIDE_LEFT]  = y_ov && (pxw == bxw + C_BW);
    side[SIDE_RIGHT] = y_ov && (pxw + C_PW == bxw);
    touch            = side[SIDE_DOWN];
  end

endmodule
`default_nettype wire

// File: rtl/collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : collision_scan_ctrl
// Description : Sequential collision scanner. On start it snapshots the
//               player position, walks the object table one block per cycle
//               through a single shared comparator and publishes the ORed
//               contact sides plus a per-block "standing on" mask.
// Ports       : clk, rst (sync, active high), start
//               x_blue, y_blue         - player position (snapshotted)
//               obj_idx -> obj_x/obj_y - table read, 1-cycle latency
//               busy, done             - scan status / result-update pulse
//               collision_state        - {right, left, up, down}
//               touched_mask           - bit k: player stands on block k
//               overrun_cnt            - only with COLL_SCAN_OVERRUN_EN:
//                                        saturating count of starts ignored
//                                        while busy
// Config      : COLL_SCAN_OVERRUN_EN (optional overrun counter)
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scan_ctrl
  import coll_pkg::*;
#(
  parameter int OBJ_NUM = 50,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [9:0]         x_blue,
  input  logic [8:0]         y_blue,
  output logic [IDX_W-1:0]   obj_idx,
  input  logic [9:0]         obj_x,
  input  logic [8:0]         obj_y,
  output logic               busy,
  output logic               done,
  output logic [3:0]         collision_state,
`ifdef COLL_SCAN_OVERRUN_EN
  output logic [7:0]         overrun_cnt,
`endif
  output logic [OBJ_NUM-1:0] touched_mask
);

  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(OBJ_NUM - 1);
  localparam logic [OBJ_NUM-1:0] C_ONE      = OBJ_NUM'(1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx_q;        // next index to issue while in SCAN
  logic               drain_q;      // second DRAIN cycle marker
  logic [9:0]         px_q;
  logic [8:0]         py_q;
  logic               issue;

  // Pipeline: issue -> table read (rd_*) -> compare register (cmp_*)
  logic               rd_v, cmp_v, cmp_touch;
  logic [IDX_W-1:0]   rd_idx, cmp_idx;
  logic [3:0]         cmp_side;
  logic [3:0]         side_w;
  logic               touch_w;
  logic [3:0]         acc_side;
  logic [OBJ_NUM-1:0] acc_mask;

  collision_cmp u_cmp (
    .px    (px_q),
    .py    (py_q),
    .bx    (obj_x),
    .by    (obj_y),
    .side  (side_w),
    .touch (touch_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    issue    = 1'b0;
    obj_idx  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LATCH;
      end
      LATCH: begin
        issue    = 1'b1;        // index 0 goes out while coordinates latch
        state_nx = SCAN;
      end
      SCAN: begin
        issue   = 1'b1;
        obj_idx = idx_q;
        if (idx_q == C_LAST_IDX) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_q) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      drain_q   <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      rd_v      <= 1'b0;
      rd_idx    <= '0;
      cmp_v     <= 1'b0;
      cmp_idx   <= '0;
      cmp_side  <= '0;
      cmp_touch <= 1'b0;
      acc_side  <= '0;
      acc_mask  <= '0;
    end else begin
      drain_q <= (state == DRAIN) && !drain_q;
      if (state == LATCH) begin
        px_q  <= x_blue;
        py_q  <= y_blue;
        idx_q <= IDX_W'(1);
      end else if (state == SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      rd_v      <= issue;
      rd_idx    <= obj_idx;
      cmp_v     <= rd_v;
      cmp_idx   <= rd_idx;
      cmp_side  <= side_w;
      cmp_touch <= touch_w;

      if (state == LATCH) begin
        acc_side <= '0;
        acc_mask <= '0;
      end else if (cmp_v) begin
        acc_side <= acc_side | cmp_side;
        if (cmp_touch) acc_mask <= acc_mask | (C_ONE << cmp_idx);
      end
    end
  end

  // Results change only here, so they stay stable between done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      done            <= 1'b0;
      collision_state <= '0;
      touched_mask    <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        collision_state <= acc_side;
        touched_mask    <= acc_mask;
      end
    end
  end

`ifdef COLL_SCAN_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)                              overrun_cnt <= '0;
    else if (start && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scan_ctrl
// Description : Self-checking bench for collision_scan_ctrl. Geometry vectors
//               load a behavioural object table (1-cycle read latency); the
//               expected result of each scan is queued at start and popped
//               when done appears. Hand sequences cover start-while-busy,
//               reset mid-scan and mid-scan coordinate changes.
// Config      : COLL_SCAN_OVERRUN_EN (also checks overrun_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scan_ctrl;

  localparam int OBJ_NUM = 50;
  localparam int IDX_W   = 6;
  localparam int DONE_CYC = OBJ_NUM + 4;

  logic               clk, rst, start;
  logic [9:0]         x_blue, obj_x;
  logic [8:0]         y_blue, obj_y;
  logic [IDX_W-1:0]   obj_idx;
  logic               busy, done;
  logic [3:0]         collision_state;
  logic [OBJ_NUM-1:0] touched_mask;
`ifdef COLL_SCAN_OVERRUN_EN
  logic [7:0]         overrun_cnt;
`endif

  collision_scan_ctrl #(.OBJ_NUM(OBJ_NUM), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .x_blue          (x_blue),
    .y_blue          (y_blue),
    .obj_idx         (obj_idx),
    .obj_x           (obj_x),
    .obj_y           (obj_y),
    .busy            (busy),
    .done            (done),
    .collision_state (collision_state),
`ifdef COLL_SCAN_OVERRUN_EN
    .overrun_cnt     (overrun_cnt),
`endif
    .touched_mask    (touched_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object table with one cycle of read latency
  logic [9:0] tab_x [OBJ_NUM];
  logic [8:0] tab_y [OBJ_NUM];
  always @(posedge clk) begin
    if (obj_idx < OBJ_NUM) begin
      obj_x <= tab_x[obj_idx];
      obj_y <= tab_y[obj_idx];
    end
  end

  typedef struct {
    logic [9:0]         px;
    logic [8:0]         py;
    int                 ia;
    logic [9:0]         ax;
    logic [8:0]         ay;
    int                 ib;
    logic [9:0]         bx;
    logic [8:0]         by;
    logic [3:0]         es;
    logic [OBJ_NUM-1:0] em;
  } vec_t;

  typedef struct packed {
    logic [3:0]         st;
    logic [OBJ_NUM-1:0] m;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int i);
    for (int k = 0; k < OBJ_NUM; k++) begin
      tab_x[k] = 10'd900;
      tab_y[k] = 9'd480;
    end
    tab_x[vecs[i].ia] = vecs[i].ax;
    tab_y[vecs[i].ia] = vecs[i].ay;
    tab_x[vecs[i].ib] = vecs[i].bx;
    tab_y[vecs[i].ib] = vecs[i].by;
    x_blue = vecs[i].px;
    y_blue = vecs[i].py;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_state"}, 64'(collision_state), 64'd0);
    check({tag, "_mask"},  64'(touched_mask), 64'd0);
    check({tag, "_idx"},   64'(obj_idx), 64'd0);
`ifdef COLL_SCAN_OVERRUN_EN
    check({tag, "_ovr"},   64'(overrun_cnt), 64'd0);
`endif
  endtask

  // mode 0: plain scan, 1: extra starts at cycles 10 and 30,
  // 2: x_blue moved at cycle 5, 3: rst pulsed at cycle 20
  task automatic run_scan(input string name, input logic [3:0] es,
                          input logic [OBJ_NUM-1:0] em, input int mode);
    int   cyc, ndone, first;
    exp_t e;
    sb_q.push_back({es, em});
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    ndone = 0;
    first = 0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (cyc < DONE_CYC + 8) begin
      if (mode == 3 && cyc == 20) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check_zero({name, "_abort"});
        return;
      end
      start = (mode == 1 && (cyc == 10 || cyc == 30));
      if (mode == 2 && cyc == 5) x_blue = 10'd600;
      tick();
      cyc++;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = cyc;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_sb: done with empty scoreboard", name);
          end else begin
            e = sb_q.pop_front();
            check({name, "_state"}, 64'(collision_state), 64'(e.st));
            check({name, "_mask"},  64'(touched_mask), 64'(e.m));
          end
        end
      end
    end
    start = 1'b0;
    check({name, "_done_cyc"}, 64'(first), 64'(DONE_CYC));
    check({name, "_ndone"}, 64'(ndone), 64'd1);
    check({name, "_hold"}, 64'(collision_state), 64'(es));
  endtask

  initial begin
    //          px    py   ia  ax   ay   ib  bx   by   state    mask
    vecs[0] = '{10'd100, 9'd333, 5,  10'd125, 9'd374, 5,  10'd125, 9'd374, 4'b0001, 50'h20};
    vecs[1] = '{10'd153, 9'd340, 0,  10'd125, 9'd345, 0,  10'd125, 9'd345, 4'b0100, 50'h0};
    vecs[2] = '{10'd200, 9'd142, 10, 10'd220, 9'd100, 10, 10'd220, 9'd100, 4'b0010, 50'h0};
    vecs[3] = '{10'd300, 9'd200, 49, 10'd347, 9'd210, 49, 10'd347, 9'd210, 4'b1000, 50'h0};
    vecs[4] = '{10'd0,   9'd0,   0,  10'd0,   9'd0,   1,  10'd10,  9'd5,   4'b0000, 50'h0};
    vecs[5] = '{10'd4,   9'd0,   7,  10'd1000,9'd0,   8,  10'd0,   9'd470, 4'b0000, 50'h0};
    vecs[6] = '{10'd100, 9'd100, 3,  10'd147, 9'd90,  20, 10'd110, 9'd141, 4'b1001, 50'h100000};
    vecs[7] = '{10'd100, 9'd333, 2,  10'd147, 9'd374, 4,  10'd73,  9'd374, 4'b0001, 50'h10};

    rst    = 1'b1;
    start  = 1'b0;
    x_blue = '0;
    y_blue = '0;
    load_vec(4);
    repeat (3) tick();
    check_zero("reset");

    // reset beats a simultaneous start
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_zero("rst_wins");
    tick();

    for (int i = 0; i < 8; i++) begin
      load_vec(i);
      run_scan($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, 0);
    end

    load_vec(0);
    run_scan("overrun", vecs[0].es, vecs[0].em, 1);
`ifdef COLL_SCAN_OVERRUN_EN
    check("overrun_cnt", 64'(overrun_cnt), 64'd2);
`endif

    load_vec(1);
    run_scan("abort", vecs[1].es, vecs[1].em, 3);
    run_scan("after_rst", vecs[1].es, vecs[1].em, 0);

    load_vec(0);
    run_scan("x_move", vecs[0].es, vecs[0].em, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
